// File: rtl/rgb2yuv422.sv
// ---------------------------------------------------------------------------
// rgb2yuv422
//   Converts 24-bit RGB pixels into a 4:2:2 YCbCr stream. Every input pixel
//   produces one output word {Y, C}. C alternates between the two chroma
//   components across each pixel pair (even slot / odd slot). Pairing restarts
//   at every rising edge of the data enable.
//
//   Pipeline (latency 4 clk_i cycles, the same for every pixel):
//     stage 1 : registered BT.601 products
//     stage 2 : registered Y/Cb/Cr sums and pixel phase
//     stage 3 : pair-hold register (even pixel waits for its odd partner)
//     stage 4 : registered chroma select/average and outputs
//
// Parameters
//   CHROMA_AVG : 1 = average chroma over each pair, 0 = use the even pixel's
//                chroma (co-sited decimation)
//   CB_FIRST   : 1 = Cb in even slots / Cr in odd slots, 0 = swapped
//
// Ports
//   clk_i  in   1   clock, rising edge
//   rst_i  in   1   synchronous active-high reset
//   vs_i   in   1   vertical sync, delayed through the pipeline unchanged
//   de_i   in   1   data enable, rgb_i valid when high
//   rgb_i  in  24   {R, G, B}, 8 bits unsigned each
//   vs_o   out  1   vs_i delayed by 4 cycles
//   de_o   out  1   de_i delayed by 4 cycles
//   yc_o   out 16   {Y, C}; 16'h1080 whenever de_o is low
// ---------------------------------------------------------------------------
module rgb2yuv422 #(
    parameter int CHROMA_AVG = 1,
    parameter int CB_FIRST   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [23:0] rgb_i,
    output logic        vs_o,
    output logic        de_o,
    output logic [15:0] yc_o
);

    localparam logic [15:0] YC_BLANK = 16'h1080;

    // Rounded mean of two 8-bit chroma samples: (a + b + 1) >> 1.
    function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: products
    // ------------------------------------------------------------------
    logic [15:0] r_s, g_s, b_s;
    assign r_s = {8'd0, rgb_i[23:16]};
    assign g_s = {8'd0, rgb_i[15:8]};
    assign b_s = {8'd0, rgb_i[7:0]};

    // Largest product is 129*255 = 32895, so 16 bits hold every term.
    logic [15:0] yr_r, yg_r, yb_r;
    logic [15:0] ur_r, ug_r, ub_r;
    logic [15:0] vr_r, vg_r, vb_r;
    logic        s1_de_r, s1_vs_r;

    // Stage 1 register: coefficient products plus control delay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            yr_r    <= 16'd0;
            yg_r    <= 16'd0;
            yb_r    <= 16'd0;
            ur_r    <= 16'd0;
            ug_r    <= 16'd0;
            ub_r    <= 16'd0;
            vr_r    <= 16'd0;
            vg_r    <= 16'd0;
            vb_r    <= 16'd0;
            s1_de_r <= 1'b0;
            s1_vs_r <= 1'b0;
        end else begin
            yr_r    <= r_s * 16'd66;
            yg_r    <= g_s * 16'd129;
            yb_r    <= b_s * 16'd25;
            ur_r    <= r_s * 16'd38;
            ug_r    <= g_s * 16'd74;
            ub_r    <= b_s * 16'd112;
            vr_r    <= r_s * 16'd112;
            vg_r    <= g_s * 16'd94;
            vb_r    <= b_s * 16'd18;
            s1_de_r <= de_i;
            s1_vs_r <= vs_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: sums and pixel phase
    // ------------------------------------------------------------------
    // The chroma sums are formed modulo 2^17. Partial results may wrap, but
    // the final value is always within 4336..61456, so bits [15:8] are exact.
    logic [16:0] y_sum_s, cb_sum_s, cr_sum_s;
    assign y_sum_s  = {1'b0, yr_r} + {1'b0, yg_r} + {1'b0, yb_r} + 17'd4224;
    assign cb_sum_s = 17'd32896 + {1'b0, ub_r} - {1'b0, ur_r} - {1'b0, ug_r};
    assign cr_sum_s = 17'd32896 + {1'b0, vr_r} - {1'b0, vg_r} - {1'b0, vb_r};

    logic [7:0] s2_y_r, s2_cb_r, s2_cr_r;
    logic       s2_de_r, s2_vs_r, s2_ph_r;
    logic       ph_next_r;   // phase the next contiguous pixel will take
    logic       de_rise_s;

    // A de rising edge at this stage starts a new line, and any de gap counts
    // as a line end.
    assign de_rise_s = s1_de_r & ~s2_de_r;

    // Stage 2 register: truncated sums, control delay and pixel phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_y_r    <= 8'd0;
            s2_cb_r   <= 8'd0;
            s2_cr_r   <= 8'd0;
            s2_de_r   <= 1'b0;
            s2_vs_r   <= 1'b0;
            s2_ph_r   <= 1'b0;
            ph_next_r <= 1'b0;
        end else begin
            s2_y_r  <= y_sum_s[15:8];
            s2_cb_r <= cb_sum_s[15:8];
            s2_cr_r <= cr_sum_s[15:8];
            s2_de_r <= s1_de_r;
            s2_vs_r <= s1_vs_r;
            if (s1_de_r) begin
                s2_ph_r   <= de_rise_s ? 1'b0 : ph_next_r;
                ph_next_r <= de_rise_s ? 1'b1 : ~ph_next_r;
            end else begin
                s2_ph_r   <= 1'b0;
                ph_next_r <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: pair hold
    // ------------------------------------------------------------------
    logic [7:0] s3_y_r, s3_cb_r, s3_cr_r;
    logic       s3_de_r, s3_vs_r, s3_ph_r;

    // Stage 3 register: holds a pixel while its successor sits in stage 2.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s3_y_r  <= 8'd0;
            s3_cb_r <= 8'd0;
            s3_cr_r <= 8'd0;
            s3_de_r <= 1'b0;
            s3_vs_r <= 1'b0;
            s3_ph_r <= 1'b0;
        end else begin
            s3_y_r  <= s2_y_r;
            s3_cb_r <= s2_cb_r;
            s3_cr_r <= s2_cr_r;
            s3_de_r <= s2_de_r;
            s3_vs_r <= s2_vs_r;
            s3_ph_r <= s2_ph_r;
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: chroma select / average and output
    // ------------------------------------------------------------------
    // An even pixel in stage 3 is paired only when stage 2 holds its odd
    // successor. A lone even pixel at a line end keeps its own chroma.
    logic       pair_s;
    logic [7:0] c1_own_s, c2_own_s, c1_next_s, c2_next_s;
    logic [7:0] first_s, second_s;
    logic [7:0] c2_hold_r;   // second chroma of the pair, used by the odd slot
    logic [15:0] yc_next_s;

    assign pair_s    = s3_de_r & ~s3_ph_r & s2_de_r & s2_ph_r;
    assign c1_own_s  = (CB_FIRST != 0) ? s3_cb_r : s3_cr_r;
    assign c2_own_s  = (CB_FIRST != 0) ? s3_cr_r : s3_cb_r;
    assign c1_next_s = (CB_FIRST != 0) ? s2_cb_r : s2_cr_r;
    assign c2_next_s = (CB_FIRST != 0) ? s2_cr_r : s2_cb_r;

    // Chroma for the pair: averaged when enabled and a partner exists.
    always_comb begin
        first_s  = c1_own_s;
        second_s = c2_own_s;
        if (pair_s && (CHROMA_AVG != 0)) begin
            first_s  = avg_round(c1_own_s, c1_next_s);
            second_s = avg_round(c2_own_s, c2_next_s);
        end else begin
            first_s  = c1_own_s;
            second_s = c2_own_s;
        end
    end

    // Output word: blank when idle, first chroma on even, held chroma on odd.
    always_comb begin
        yc_next_s = YC_BLANK;
        if (!s3_de_r) begin
            yc_next_s = YC_BLANK;
        end else if (!s3_ph_r) begin
            yc_next_s = {s3_y_r, first_s};
        end else begin
            yc_next_s = {s3_y_r, c2_hold_r};
        end
    end

    // Stage 4 register: outputs and the held second chroma.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            yc_o      <= YC_BLANK;
            de_o      <= 1'b0;
            vs_o      <= 1'b0;
            c2_hold_r <= 8'd0;
        end else begin
            yc_o <= yc_next_s;
            de_o <= s3_de_r;
            vs_o <= s3_vs_r;
            if (s3_de_r && !s3_ph_r) begin
                c2_hold_r <= second_s;
            end else begin
                c2_hold_r <= c2_hold_r;
            end
        end
    end

endmodule

// File: tb/tb_rgb2yuv422.sv
// ---------------------------------------------------------------------------
// tb_rgb2yuv422
//   Drives three instances (defaults / co-sited chroma / Cr-first) with the
//   same stimulus. Directed vectors carry hand-computed results. A random
//   section derives its results from a line-level reference model. A
//   hand-written sequence covers the mid-line reset.
// ---------------------------------------------------------------------------
module tb_rgb2yuv422;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vs  = 1'b0;
    logic        de  = 1'b0;
    logic [23:0] rgb = 24'd0;

    logic        vs0, vs1, vs2, de0, de1, de2;
    logic [15:0] yc0, yc1, yc2;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [23:0] WHT = 24'hFFFFFF;
    localparam logic [23:0] BLK = 24'h000000;
    localparam logic [23:0] RED = 24'hFF0000;
    localparam logic [23:0] BLU = 24'h0000FF;
    localparam logic [15:0] IDL = 16'h1080;

    always #5 clk = ~clk;

    rgb2yuv422 #(.CHROMA_AVG(1), .CB_FIRST(1)) u_def (
        .clk_i(clk), .rst_i(rst), .vs_i(vs), .de_i(de), .rgb_i(rgb),
        .vs_o(vs0), .de_o(de0), .yc_o(yc0));
    rgb2yuv422 #(.CHROMA_AVG(0), .CB_FIRST(1)) u_cos (
        .clk_i(clk), .rst_i(rst), .vs_i(vs), .de_i(de), .rgb_i(rgb),
        .vs_o(vs1), .de_o(de1), .yc_o(yc1));
    rgb2yuv422 #(.CHROMA_AVG(1), .CB_FIRST(0)) u_crf (
        .clk_i(clk), .rst_i(rst), .vs_i(vs), .de_i(de), .rgb_i(rgb),
        .vs_o(vs2), .de_o(de2), .yc_o(yc2));

    typedef struct {
        logic        vs;
        logic        de;
        logic [23:0] rgb;
        logic [15:0] e0, e1, e2;   // expected yc for def / co-sited / Cr-first
    } vec_t;

    typedef struct {
        logic        rst;
        logic        de;
        logic [23:0] rgb;
        logic        exp_de;
        logic [15:0] e0, e1, e2;
    } hs_t;

    vec_t tbl[$];
    hs_t  hs[$];

    task automatic add(input logic v, input logic d, input logic [23:0] p,
                       input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        vec_t t;
        t.vs = v; t.de = d; t.rgb = p; t.e0 = e0; t.e1 = e1; t.e2 = e2;
        tbl.push_back(t);
    endtask

    task automatic addh(input logic r, input logic d, input logic [23:0] p, input logic ed,
                        input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        hs_t t;
        t.rst = r; t.de = d; t.rgb = p; t.exp_de = ed; t.e0 = e0; t.e1 = e1; t.e2 = e2;
        hs.push_back(t);
    endtask

    // Reference colour conversion on plain integers.
    function automatic int f_y(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
        return (66 * r + 129 * g + 25 * b + 4224) / 256;
    endfunction
    function automatic int f_cb(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
        return (112 * b - 38 * r - 74 * g + 32896) / 256;
    endfunction
    function automatic int f_cr(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
        return (112 * r - 94 * g - 18 * b + 32896) / 256;
    endfunction

    // Line-level model: phase from the run length of de, pairing from the
    // neighbouring table rows.
    function automatic logic [15:0] model(input int k, input bit avg, input bit cbf);
        int run, y, c, ca, cb_;
        logic [7:0] c8, y8;
        if (!tbl[k].de) return IDL;
        run = 0;
        while (k - run - 1 >= 0 && tbl[k - run - 1].de) run++;
        y = f_y(tbl[k].rgb);
        if (run % 2 == 0) begin
            ca = cbf ? f_cb(tbl[k].rgb) : f_cr(tbl[k].rgb);
            c  = ca;
            if (avg && (k + 1 < tbl.size()) && tbl[k + 1].de) begin
                cb_ = cbf ? f_cb(tbl[k + 1].rgb) : f_cr(tbl[k + 1].rgb);
                c   = (ca + cb_ + 1) / 2;
            end
        end else begin
            ca = cbf ? f_cr(tbl[k - 1].rgb) : f_cb(tbl[k - 1].rgb);
            c  = ca;
            if (avg) begin
                cb_ = cbf ? f_cr(tbl[k].rgb) : f_cb(tbl[k].rgb);
                c   = (ca + cb_ + 1) / 2;
            end
        end
        y8 = 8'(y); c8 = 8'(c);
        return {y8, c8};
    endfunction

    task automatic check(input string nm, input logic evs, input logic ede,
                         input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        n_vec++;
        if (vs0 !== evs || vs1 !== evs || vs2 !== evs ||
            de0 !== ede || de1 !== ede || de2 !== ede ||
            yc0 !== e0 || yc1 !== e1 || yc2 !== e2) begin
            n_miss++;
            $display("FAIL %s: got vs=%b%b%b de=%b%b%b yc=%h/%h/%h, want vs=%b de=%b yc=%h/%h/%h",
                     nm, vs0, vs1, vs2, de0, de1, de2, yc0, yc1, yc2, evs, ede, e0, e1, e2);
        end
    endtask

    initial begin
        int start;
        // ---------------- directed table ----------------
        add(1'b1, 1'b0, BLK, IDL, IDL, IDL);
        add(1'b0, 1'b0, WHT, IDL, IDL, IDL);
        add(1'b0, 1'b1, WHT, 16'hEB80, 16'hEB80, 16'hEB80);
        add(1'b0, 1'b0, RED, IDL, IDL, IDL);
        add(1'b0, 1'b1, BLK, 16'h1080, 16'h1080, 16'h1080);
        add(1'b0, 1'b0, WHT, IDL, IDL, IDL);
        add(1'b0, 1'b1, RED, 16'h52A5, 16'h525A, 16'h52AF);
        add(1'b0, 1'b1, BLU, 16'h29AF, 16'h29F0, 16'h29A5);
        add(1'b0, 1'b0, BLK, IDL, IDL, IDL);
        add(1'b0, 1'b1, WHT, 16'hEB80, 16'hEB80, 16'hEB80);
        add(1'b0, 1'b1, WHT, 16'hEB80, 16'hEB80, 16'hEB80);
        add(1'b0, 1'b1, RED, 16'h525A, 16'h525A, 16'h52F0);
        add(1'b0, 1'b0, BLU, IDL, IDL, IDL);
        add(1'b1, 1'b1, RED, 16'h52A5, 16'h525A, 16'h52AF);
        add(1'b0, 1'b1, BLU, 16'h29AF, 16'h29F0, 16'h29A5);
        add(1'b0, 1'b0, BLK, IDL, IDL, IDL);
        add(1'b0, 1'b1, BLU, 16'h29A5, 16'h29F0, 16'h29AF);
        add(1'b0, 1'b1, RED, 16'h52AF, 16'h526E, 16'h52A5);
        add(1'b0, 1'b0, BLK, IDL, IDL, IDL);
        // ---------------- random section ----------------
        start = tbl.size();
        for (int i = 0; i < 160; i++)
            add(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                24'($urandom), IDL, IDL, IDL);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, BLK, IDL, IDL, IDL);
        for (int k = start; k < tbl.size(); k++) begin
            tbl[k].e0 = model(k, 1'b1, 1'b1);
            tbl[k].e1 = model(k, 1'b0, 1'b1);
            tbl[k].e2 = model(k, 1'b1, 1'b0);
        end
        // ---------------- mid-line reset sequence ----------------
        addh(1'b0, 1'b1, RED, 1'b0, IDL, IDL, IDL);
        addh(1'b0, 1'b1, BLU, 1'b0, IDL, IDL, IDL);
        addh(1'b0, 1'b1, RED, 1'b0, IDL, IDL, IDL);
        addh(1'b0, 1'b1, BLU, 1'b1, 16'h52A5, 16'h525A, 16'h52AF);
        addh(1'b1, 1'b1, RED, 1'b0, IDL, IDL, IDL);
        addh(1'b0, 1'b1, BLU, 1'b0, IDL, IDL, IDL);
        addh(1'b0, 1'b1, RED, 1'b0, IDL, IDL, IDL);
        addh(1'b0, 1'b1, BLU, 1'b0, IDL, IDL, IDL);
        addh(1'b0, 1'b1, RED, 1'b1, 16'h29A5, 16'h29F0, 16'h29AF);
        addh(1'b0, 1'b1, BLU, 1'b1, 16'h52AF, 16'h526E, 16'h52A5);
        addh(1'b0, 1'b0, BLK, 1'b1, 16'h29A5, 16'h29F0, 16'h29AF);
        addh(1'b0, 1'b0, BLK, 1'b1, 16'h52AF, 16'h526E, 16'h52A5);
        addh(1'b0, 1'b0, BLK, 1'b1, 16'h29F0, 16'h29F0, 16'h296E);
        addh(1'b0, 1'b1, RED, 1'b0, IDL, IDL, IDL);
        addh(1'b0, 1'b1, BLU, 1'b0, IDL, IDL, IDL);
        addh(1'b0, 1'b0, BLK, 1'b0, IDL, IDL, IDL);
        addh(1'b0, 1'b0, BLK, 1'b1, 16'h52A5, 16'h525A, 16'h52AF);
        addh(1'b0, 1'b0, BLK, 1'b1, 16'h29AF, 16'h29F0, 16'h29A5);
        addh(1'b0, 1'b0, BLK, 1'b0, IDL, IDL, IDL);

        // ---------------- reset state ----------------
        rst = 1'b1; vs = 1'b1; de = 1'b1; rgb = WHT;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 1'b0, 1'b0, IDL, IDL, IDL);
        rst = 1'b0; vs = 1'b0; de = 1'b0; rgb = BLK;
        repeat (4) @(posedge clk);
        #1;

        // ---------------- apply table (output lags input by 3 edges + capture) ----------------
        for (int i = 0; i < tbl.size() + 3; i++) begin
            if (i < tbl.size()) begin
                vs = tbl[i].vs; de = tbl[i].de; rgb = tbl[i].rgb;
            end else begin
                vs = 1'b0; de = 1'b0; rgb = BLK;
            end
            @(posedge clk);
            #1;
            if (i >= 3)
                check($sformatf("vec%0d", i - 3), tbl[i - 3].vs, tbl[i - 3].de,
                      tbl[i - 3].e0, tbl[i - 3].e1, tbl[i - 3].e2);
        end

        // ---------------- mid-line reset ----------------
        for (int i = 0; i < hs.size(); i++) begin
            rst = hs[i].rst; vs = 1'b0; de = hs[i].de; rgb = hs[i].rgb;
            @(posedge clk);
            #1;
            check($sformatf("rst_seq%0d", i), 1'b0, hs[i].exp_de, hs[i].e0, hs[i].e1, hs[i].e2);
        end
        rst = 1'b0; de = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
